// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the 32-bit MIPS R/I datapath.
// Steps each instruction through IF/ID/EX/MRD/MWR/WB/BR/JMP and drives
// every datapath mux select and write strobe. It also counts the
// instructions that complete legally.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | halted, no strobes; leave for IF when run=1
// IF    | load IR, PC <= PC+4
// ID    | latch register-file read data into A/B, classify instruction
// EX    | ALU operation, optional flag update
// MRD   | RAM read cycle for lw
// MWR   | RAM write for sw (final)
// WB    | register-file write (final)
// BR    | beq compare, PC <= branch target when ZF (final)
// JMP   | PC <= jump target (final)
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  OP,
    input  logic [5:0]  func,
    input  logic        ZF,
    output logic        PC_Write,
    output logic [1:0]  PC_Src,
    output logic        IR_Write,
    output logic        AB_Write,
    output logic [2:0]  ALU_OP,
    output logic        imm_s,
    output logic        rt_imm_s,
    output logic        rd_rt_s,
    output logic        alu_mem_s,
    output logic        Write_Reg,
    output logic        Mem_Write,
    output logic        Set_ZF,
    output logic        Set_OF,
    output logic [3:0]  state,
    output logic        inst_done,
    output logic        illegal,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_IF   = 4'd1,
        S_ID   = 4'd2,
        S_EX   = 4'd3,
        S_MRD  = 4'd4,
        S_MWR  = 4'd5,
        S_WB   = 4'd6,
        S_BR   = 4'd7,
        S_JMP  = 4'd8
    } state_t;

    state_t state_q, state_d;

    logic       dec_legal, dec_alu, dec_lw, dec_sw, dec_beq, dec_j, dec_of;
    logic [2:0] dec_op;
    logic       dec_imm, dec_rt_imm, dec_rd_rt, dec_alu_mem;

    // Instruction decode from the IR fields; IR keeps these stable from ID on.
    always_comb begin
        dec_legal   = 1'b1;
        dec_alu     = 1'b0;
        dec_lw      = 1'b0;
        dec_sw      = 1'b0;
        dec_beq     = 1'b0;
        dec_j       = 1'b0;
        dec_of      = 1'b0;
        dec_op      = 3'b000;
        dec_imm     = 1'b0;
        dec_rt_imm  = 1'b0;
        dec_rd_rt   = 1'b0;
        dec_alu_mem = 1'b0;
        case (OP)
            6'b000000: begin
                dec_alu = 1'b1;
                case (func)
                    6'b100000: begin dec_op = 3'b100; dec_of = 1'b1; end
                    6'b100010: begin dec_op = 3'b101; dec_of = 1'b1; end
                    6'b100100: dec_op = 3'b000;
                    6'b100101: dec_op = 3'b001;
                    6'b100110: dec_op = 3'b010;
                    6'b100111: dec_op = 3'b011;
                    6'b101011: dec_op = 3'b110;
                    6'b000100: dec_op = 3'b111;
                    default: begin dec_legal = 1'b0; dec_alu = 1'b0; end
                endcase
            end
            6'b001000: begin
                dec_alu = 1'b1; dec_op = 3'b100; dec_of = 1'b1; dec_imm = 1'b1;
                dec_rt_imm = 1'b1; dec_rd_rt = 1'b1;
            end
            6'b001100: begin
                dec_alu = 1'b1; dec_op = 3'b000; dec_rt_imm = 1'b1; dec_rd_rt = 1'b1;
            end
            6'b001110: begin
                dec_alu = 1'b1; dec_op = 3'b010; dec_rt_imm = 1'b1; dec_rd_rt = 1'b1;
            end
            6'b001011: begin
                dec_alu = 1'b1; dec_op = 3'b110; dec_rt_imm = 1'b1; dec_rd_rt = 1'b1;
            end
            6'b100011: begin
                dec_lw = 1'b1; dec_op = 3'b100; dec_imm = 1'b1; dec_rt_imm = 1'b1;
                dec_rd_rt = 1'b1; dec_alu_mem = 1'b1;
            end
            6'b101011: begin
                dec_sw = 1'b1; dec_op = 3'b100; dec_imm = 1'b1; dec_rt_imm = 1'b1;
            end
            6'b000100: dec_beq = 1'b1;
            6'b000010: dec_j   = 1'b1;
            default:   dec_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and outputs; reset suppresses every strobe and pulse.
    always_comb begin
        state_d   = S_IDLE;
        PC_Write  = 1'b0;
        PC_Src    = 2'b00;
        IR_Write  = 1'b0;
        AB_Write  = 1'b0;
        ALU_OP    = 3'b000;
        imm_s     = 1'b0;
        rt_imm_s  = 1'b0;
        rd_rt_s   = 1'b0;
        alu_mem_s = 1'b0;
        Write_Reg = 1'b0;
        Mem_Write = 1'b0;
        Set_ZF    = 1'b0;
        Set_OF    = 1'b0;
        inst_done = 1'b0;
        illegal   = 1'b0;
        if (state_q != S_IDLE && state_q != S_IF) begin
            ALU_OP    = dec_op;
            imm_s     = dec_imm;
            rt_imm_s  = dec_rt_imm;
            rd_rt_s   = dec_rd_rt;
            alu_mem_s = dec_alu_mem;
        end
        case (state_q)
            S_IDLE: state_d = run ? S_IF : S_IDLE;
            S_IF: begin
                IR_Write = 1'b1;
                PC_Write = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                AB_Write = 1'b1;
                if (!dec_legal) begin
                    illegal = 1'b1;
                    state_d = run ? S_IF : S_IDLE;
                end else if (dec_beq) state_d = S_BR;
                else if (dec_j)       state_d = S_JMP;
                else                  state_d = S_EX;
            end
            S_EX: begin
                Set_ZF  = dec_alu;
                Set_OF  = dec_alu & dec_of;
                state_d = dec_lw ? S_MRD : (dec_sw ? S_MWR : S_WB);
            end
            S_MRD: state_d = S_WB;
            S_MWR: begin
                Mem_Write = 1'b1;
                inst_done = 1'b1;
                state_d   = run ? S_IF : S_IDLE;
            end
            S_WB: begin
                Write_Reg = 1'b1;
                inst_done = 1'b1;
                state_d   = run ? S_IF : S_IDLE;
            end
            S_BR: begin
                ALU_OP    = 3'b101;
                PC_Src    = 2'b01;
                PC_Write  = ZF;
                inst_done = 1'b1;
                state_d   = run ? S_IF : S_IDLE;
            end
            S_JMP: begin
                PC_Src    = 2'b10;
                PC_Write  = 1'b1;
                inst_done = 1'b1;
                state_d   = run ? S_IF : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            PC_Write  = 1'b0;
            PC_Src    = 2'b00;
            IR_Write  = 1'b0;
            AB_Write  = 1'b0;
            Write_Reg = 1'b0;
            Mem_Write = 1'b0;
            Set_ZF    = 1'b0;
            Set_OF    = 1'b0;
            inst_done = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign state = state_q;

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)            retired <= 32'd0;
        else if (inst_done) retired <= retired + 32'd1;
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven check of mc_ctrl plus a reset-in-WB sequence.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, ZF;
    logic [5:0]  OP, func;
    logic        PC_Write, IR_Write, AB_Write;
    logic [1:0]  PC_Src;
    logic [2:0]  ALU_OP;
    logic        imm_s, rt_imm_s, rd_rt_s, alu_mem_s;
    logic        Write_Reg, Mem_Write, Set_ZF, Set_OF;
    logic [3:0]  state;
    logic        inst_done, illegal;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .OP(OP), .func(func), .ZF(ZF),
        .PC_Write(PC_Write), .PC_Src(PC_Src), .IR_Write(IR_Write),
        .AB_Write(AB_Write), .ALU_OP(ALU_OP), .imm_s(imm_s),
        .rt_imm_s(rt_imm_s), .rd_rt_s(rd_rt_s), .alu_mem_s(alu_mem_s),
        .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .Set_ZF(Set_ZF),
        .Set_OF(Set_OF), .state(state), .inst_done(inst_done),
        .illegal(illegal), .retired(retired)
    );

    typedef struct {
        logic       rst, run;
        logic [5:0] op, func;
        logic       zf;
        logic [3:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw, abw;
        logic [2:0] aop;
        logic [3:0] sel;   // {imm_s, rt_imm_s, rd_rt_s, alu_mem_s}
        logic       wr, mw, szf, sof, done, ill;
    } vec_t;

    vec_t vq[$];

    localparam logic [5:0] F_ADD = 6'h20, F_SLTU = 6'h2B, F_BAD = 6'h00;
    localparam logic [5:0] O_R = 6'h00, O_LW = 6'h23, O_SW = 6'h2B, O_BEQ = 6'h04;
    localparam logic [5:0] O_J = 6'h02, O_ADDI = 6'h08, O_BAD = 6'h3F;

    function automatic void addv(logic r, logic rn, logic [5:0] op, logic [5:0] fn,
                                 logic zf, logic [3:0] st, logic pcw, logic [1:0] pcs,
                                 logic irw, logic abw, logic [2:0] aop, logic [3:0] sel,
                                 logic wr, logic mw, logic szf, logic sof,
                                 logic done, logic ill);
        vec_t v;
        v.rst = r; v.run = rn; v.op = op; v.func = fn; v.zf = zf; v.st = st;
        v.pcw = pcw; v.pcs = pcs; v.irw = irw; v.abw = abw; v.aop = aop;
        v.sel = sel; v.wr = wr; v.mw = mw; v.szf = szf; v.sof = sof;
        v.done = done; v.ill = ill;
        vq.push_back(v);
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    // Fetch row shared by every instruction: IR and PC load, selects 0.
    function automatic void add_if(logic rn, logic [5:0] op, logic [5:0] fn, logic zf);
        addv(0, rn, op, fn, zf, 4'd1, 1, 2'b00, 1, 0, 3'b000, 4'h0, 0, 0, 0, 0, 0, 0);
    endfunction

    int ret_exp;

    initial begin
        // reset row, then IDLE held with run=0
        addv(1, 1, O_R, F_ADD, 0, 4'd0, 0, 2'b00, 0, 0, 3'b000, 4'h0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            addv(0, 0, O_R, F_ADD, 0, 4'd0, 0, 2'b00, 0, 0, 3'b000, 4'h0, 0, 0, 0, 0, 0, 0);
        // add $3,$1,$2
        addv(0, 1, O_R, F_ADD, 0, 4'd0, 0, 2'b00, 0, 0, 3'b000, 4'h0, 0, 0, 0, 0, 0, 0);
        add_if(1, O_R, F_ADD, 0);
        addv(0, 1, O_R, F_ADD, 0, 4'd2, 0, 2'b00, 0, 1, 3'b100, 4'h0, 0, 0, 0, 0, 0, 0);
        addv(0, 1, O_R, F_ADD, 0, 4'd3, 0, 2'b00, 0, 0, 3'b100, 4'h0, 0, 0, 1, 1, 0, 0);
        addv(0, 1, O_R, F_ADD, 0, 4'd6, 0, 2'b00, 0, 0, 3'b100, 4'h0, 1, 0, 0, 0, 1, 0);
        // lw
        add_if(1, O_LW, F_ADD, 0);
        addv(0, 1, O_LW, F_ADD, 0, 4'd2, 0, 2'b00, 0, 1, 3'b100, 4'hF, 0, 0, 0, 0, 0, 0);
        addv(0, 1, O_LW, F_ADD, 0, 4'd3, 0, 2'b00, 0, 0, 3'b100, 4'hF, 0, 0, 0, 0, 0, 0);
        addv(0, 1, O_LW, F_ADD, 0, 4'd4, 0, 2'b00, 0, 0, 3'b100, 4'hF, 0, 0, 0, 0, 0, 0);
        addv(0, 1, O_LW, F_ADD, 0, 4'd6, 0, 2'b00, 0, 0, 3'b100, 4'hF, 1, 0, 0, 0, 1, 0);
        // sltu: flags Z only
        add_if(1, O_R, F_SLTU, 0);
        addv(0, 1, O_R, F_SLTU, 0, 4'd2, 0, 2'b00, 0, 1, 3'b110, 4'h0, 0, 0, 0, 0, 0, 0);
        addv(0, 1, O_R, F_SLTU, 0, 4'd3, 0, 2'b00, 0, 0, 3'b110, 4'h0, 0, 0, 1, 0, 0, 0);
        addv(0, 1, O_R, F_SLTU, 0, 4'd6, 0, 2'b00, 0, 0, 3'b110, 4'h0, 1, 0, 0, 0, 1, 0);
        // beq taken
        add_if(1, O_BEQ, F_ADD, 1);
        addv(0, 1, O_BEQ, F_ADD, 1, 4'd2, 0, 2'b00, 0, 1, 3'b000, 4'h0, 0, 0, 0, 0, 0, 0);
        addv(0, 1, O_BEQ, F_ADD, 1, 4'd7, 1, 2'b01, 0, 0, 3'b101, 4'h0, 0, 0, 0, 0, 1, 0);
        // beq not taken
        add_if(1, O_BEQ, F_ADD, 0);
        addv(0, 1, O_BEQ, F_ADD, 0, 4'd2, 0, 2'b00, 0, 1, 3'b000, 4'h0, 0, 0, 0, 0, 0, 0);
        addv(0, 1, O_BEQ, F_ADD, 0, 4'd7, 0, 2'b01, 0, 0, 3'b101, 4'h0, 0, 0, 0, 0, 1, 0);
        // j
        add_if(1, O_J, F_ADD, 0);
        addv(0, 1, O_J, F_ADD, 0, 4'd2, 0, 2'b00, 0, 1, 3'b000, 4'h0, 0, 0, 0, 0, 0, 0);
        addv(0, 1, O_J, F_ADD, 0, 4'd8, 1, 2'b10, 0, 0, 3'b000, 4'h0, 0, 0, 0, 0, 1, 0);
        // illegal OP, then illegal R-type func
        add_if(1, O_BAD, F_ADD, 0);
        addv(0, 1, O_BAD, F_ADD, 0, 4'd2, 0, 2'b00, 0, 1, 3'b000, 4'h0, 0, 0, 0, 0, 0, 1);
        add_if(1, O_R, F_BAD, 0);
        addv(0, 1, O_R, F_BAD, 0, 4'd2, 0, 2'b00, 0, 1, 3'b000, 4'h0, 0, 0, 0, 0, 0, 1);
        // addi
        add_if(1, O_ADDI, F_ADD, 0);
        addv(0, 1, O_ADDI, F_ADD, 0, 4'd2, 0, 2'b00, 0, 1, 3'b100, 4'hE, 0, 0, 0, 0, 0, 0);
        addv(0, 1, O_ADDI, F_ADD, 0, 4'd3, 0, 2'b00, 0, 0, 3'b100, 4'hE, 0, 0, 1, 1, 0, 0);
        addv(0, 1, O_ADDI, F_ADD, 0, 4'd6, 0, 2'b00, 0, 0, 3'b100, 4'hE, 1, 0, 0, 0, 1, 0);
        // sw with run dropped in EX
        add_if(1, O_SW, F_ADD, 0);
        addv(0, 1, O_SW, F_ADD, 0, 4'd2, 0, 2'b00, 0, 1, 3'b100, 4'hC, 0, 0, 0, 0, 0, 0);
        addv(0, 0, O_SW, F_ADD, 0, 4'd3, 0, 2'b00, 0, 0, 3'b100, 4'hC, 0, 0, 0, 0, 0, 0);
        addv(0, 0, O_SW, F_ADD, 0, 4'd5, 0, 2'b00, 0, 0, 3'b100, 4'hC, 0, 1, 0, 0, 1, 0);
        addv(0, 0, O_SW, F_ADD, 0, 4'd0, 0, 2'b00, 0, 0, 3'b000, 4'h0, 0, 0, 0, 0, 0, 0);

        rst = 1'b1; run = 1'b0; OP = O_R; func = F_ADD; ZF = 1'b0;
        repeat (2) @(posedge clk);
        ret_exp = 0;

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; run = vq[i].run; OP = vq[i].op;
            func = vq[i].func; ZF = vq[i].zf;
            #1;
            chk("state",     i, 32'(state),     32'(vq[i].st));
            chk("PC_Write",  i, 32'(PC_Write),  32'(vq[i].pcw));
            chk("PC_Src",    i, 32'(PC_Src),    32'(vq[i].pcs));
            chk("IR_Write",  i, 32'(IR_Write),  32'(vq[i].irw));
            chk("AB_Write",  i, 32'(AB_Write),  32'(vq[i].abw));
            if (vq[i].st == 4'd3 || vq[i].st == 4'd7)
                chk("ALU_OP", i, 32'(ALU_OP), 32'(vq[i].aop));
            chk("selects",   i, 32'({imm_s, rt_imm_s, rd_rt_s, alu_mem_s}), 32'(vq[i].sel));
            chk("Write_Reg", i, 32'(Write_Reg), 32'(vq[i].wr));
            chk("Mem_Write", i, 32'(Mem_Write), 32'(vq[i].mw));
            chk("Set_ZF",    i, 32'(Set_ZF),    32'(vq[i].szf));
            chk("Set_OF",    i, 32'(Set_OF),    32'(vq[i].sof));
            chk("inst_done", i, 32'(inst_done), 32'(vq[i].done));
            chk("illegal",   i, 32'(illegal),   32'(vq[i].ill));
            chk("retired",   i, retired,        32'(ret_exp));
            if (vq[i].rst)       ret_exp = 0;
            else if (vq[i].done) ret_exp++;
        end

        // reset asserted in the WB cycle of an add
        @(negedge clk); run = 1'b1; OP = O_R; func = F_ADD;
        repeat (4) @(negedge clk);   // IDLE->IF->ID->EX->WB
        #1;
        chk("pre_rst_state", 900, 32'(state), 32'd6);
        rst = 1'b1;
        #1;
        chk("rst_wb_write", 901, 32'(Write_Reg), 32'd0);
        chk("rst_wb_done",  902, 32'(inst_done), 32'd0);
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
        #1;
        chk("rst_wb_state",   903, 32'(state), 32'd0);
        chk("rst_wb_retired", 904, retired, 32'd0);
        @(negedge clk);
        #1;
        chk("idle_after_rst", 905, 32'(state), 32'd0);
        chk("idle_no_irw",    906, 32'(IR_Write), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
